pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush controller for the 5-stage MIPS pipeline.
//  - Drives the enable and flush pins of the PC, IF_ID, ID_EX and EX_MEM registers.
//  - Detects load-use hazards and resolves taken branches (EX) and exceptions.
//  - Sequences the multi-cycle MUL/DIV unit and its HI/LO write-back.
//  - Keeps a stall-cycle performance counter.

---
 rtl/pipe_ctrl_pkg.sv | 10 +
 rtl/md_sequencer.sv | 68 ++++++
 rtl/pipeline_hazard_ctrl.sv | 106 ++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
//   ctrl_state_t : MUL/DIV sequencer state (RUN = idle, MD_BUSY = in flight)
//   REG_ADDR_W   : register-file address width
package pipe_ctrl_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic {RUN, MD_BUSY} ctrl_state_t;

endpackage

// File: rtl/md_sequencer.sv
// MUL/DIV sequencer: tracks one multi-cycle operation from accept to the
// HI/LO write strobe.
// Ports:
//   clk_i      rising-edge clock
//   rst_ni     synchronous active-low reset
//   start_i    operands accepted this cycle (only honoured in RUN)
//   abort_i    exception flush; drops an in-flight operation
//   busy_o     operation in flight (stays high through the hilo_we cycle)
//   hilo_we_o  one-cycle HI/LO write strobe, MD_LATENCY cycles after start_i
module md_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MD_LATENCY = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  input  logic abort_i,
  output logic busy_o,
  output logic hilo_we_o
);

  localparam int unsigned     CNT_W    = $clog2(MD_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LATENCY - 1);

  ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hilo_we_o = 1'b0;
    case (state_q)
      RUN: begin
        if (start_i) begin
          state_d = MD_BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      MD_BUSY: begin
        if (abort_i) begin
          // Exception wins even on the final cycle: no write-back.
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          hilo_we_o = rst_ni;
          state_d   = RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign busy_o = (state_q == MD_BUSY);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage MIPS pipeline.
// Priority: exception > taken branch > MUL/DIV stall > load-use stall > run.
// Ports:
//   clk, rst (sync, active-low)
//   id_rs, id_rt, id_uses_rt, id_md_start, id_reads_hilo : ID-stage decode
//   idex_mem_read, idex_rt                               : load in ID_EX
//   ex_branch_taken, exc_req                             : flush requests
//   pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush : pipe controls
//   md_accept, md_busy, hilo_we                          : MUL/DIV handshake
//   stall_cycles                                         : saturating stall count
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W = pipe_ctrl_pkg::REG_ADDR_W,
  parameter int unsigned MD_LATENCY = 8,
  parameter int unsigned PERF_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  id_md_start,
  input  logic                  id_reads_hilo,
  input  logic                  idex_mem_read,
  input  logic [REG_ADDR_W-1:0] idex_rt,
  input  logic                  ex_branch_taken,
  input  logic                  exc_req,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_flush,
  output logic                  md_accept,
  output logic                  md_busy,
  output logic                  hilo_we,
  output logic [PERF_W-1:0]     stall_cycles
);

  logic md_stall;
  logic load_use;
  logic stall_win;

  logic [PERF_W-1:0] stall_q, stall_d;

  assign md_stall = md_busy && (id_md_start || id_reads_hilo);
  assign load_use = idex_mem_read && (idex_rt != '0) &&
                    ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    md_accept    = 1'b0;
    stall_win    = 1'b0;
    if (!rst) begin
      pc_en    = 1'b0;
      if_id_en = 1'b0;
    end else if (exc_req) begin
      pc_en        = 1'b1;
      if_id_en     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (md_stall || load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
      stall_win   = 1'b1;
    end else begin
      md_accept = id_md_start && !md_busy;
    end
  end

  md_sequencer #(
    .MD_LATENCY(MD_LATENCY)
  ) u_md_seq (
    .clk_i    (clk),
    .rst_ni   (rst),
    .start_i  (md_accept),
    .abort_i  (exc_req),
    .busy_o   (md_busy),
    .hilo_we_o(hilo_we)
  );

  always_comb begin
    stall_d = stall_q;
    if (stall_win && (stall_q != '1)) begin
      stall_d = stall_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, idex_rt;
  logic       id_uses_rt, id_md_start, id_reads_hilo, idex_mem_read;
  logic       ex_branch_taken, exc_req;

  logic        pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush;
  logic        md_accept, md_busy, hilo_we;
  logic [31:0] stall_cycles;

  // Narrow-counter instance to exercise saturation.
  logic       s_pc_en, s_if_id_en, s_if_id_flush, s_id_ex_flush, s_ex_mem_flush;
  logic       s_md_accept, s_md_busy, s_hilo_we;
  logic [1:0] s_stall;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .MD_LATENCY(8), .PERF_W(32)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_md_start(id_md_start), .id_reads_hilo(id_reads_hilo),
    .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
    .ex_branch_taken(ex_branch_taken), .exc_req(exc_req),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .md_accept(md_accept), .md_busy(md_busy), .hilo_we(hilo_we),
    .stall_cycles(stall_cycles)
  );

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .MD_LATENCY(8), .PERF_W(2)) u_sat (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_md_start(id_md_start), .id_reads_hilo(id_reads_hilo),
    .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
    .ex_branch_taken(ex_branch_taken), .exc_req(exc_req),
    .pc_en(s_pc_en), .if_id_en(s_if_id_en), .if_id_flush(s_if_id_flush),
    .id_ex_flush(s_id_ex_flush), .ex_mem_flush(s_ex_mem_flush),
    .md_accept(s_md_accept), .md_busy(s_md_busy), .hilo_we(s_hilo_we),
    .stall_cycles(s_stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic idle();
    id_rs = '0; id_rt = '0; idex_rt = '0;
    id_uses_rt = 0; id_md_start = 0; id_reads_hilo = 0; idex_mem_read = 0;
    ex_branch_taken = 0; exc_req = 0;
  endtask

  // Advance one clock; inputs are then driven and outputs sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    #1;

    // 1: reset with random inputs
    for (int i = 0; i < 3; i++) begin
      {id_rs, id_rt, idex_rt} = 15'($urandom);
      {id_uses_rt, id_md_start, id_reads_hilo, idex_mem_read, ex_branch_taken, exc_req} = 6'($urandom);
      #1;
      chk("rst_pc_en", 32'(pc_en), 0);
      chk("rst_if_id_en", 32'(if_id_en), 0);
      chk("rst_flushes", {29'd0, if_id_flush, id_ex_flush, ex_mem_flush}, 0);
      chk("rst_md_accept", 32'(md_accept), 0);
      chk("rst_hilo_we", 32'(hilo_we), 0);
      tick();
    end
    chk("rst_stall", stall_cycles, 0);
    chk("rst_sat_stall", 32'(s_stall), 0);
    chk("rst_md_busy", 32'(md_busy), 0);
    idle();
    rst = 1'b1;
    #1;
    chk("run_pc_en", 32'(pc_en), 1);
    chk("run_if_id_en", 32'(if_id_en), 1);
    tick();

    // 2: load-use on rs
    idex_mem_read = 1; idex_rt = 5; id_rs = 5;
    #1;
    chk("lu_rs_pc_en", 32'(pc_en), 0);
    chk("lu_rs_if_id_en", 32'(if_id_en), 0);
    chk("lu_rs_id_ex_flush", 32'(id_ex_flush), 1);
    chk("lu_rs_if_id_flush", 32'(if_id_flush), 0);
    tick();
    chk("lu_rs_stall", stall_cycles, 1);
    // load-use on rt
    id_rs = 3; id_rt = 5; id_uses_rt = 1;
    #1;
    chk("lu_rt_pc_en", 32'(pc_en), 0);
    tick();
    chk("lu_rt_stall", stall_cycles, 2);
    // rt matches but not read
    id_uses_rt = 0;
    #1;
    chk("lu_rt_unused_pc_en", 32'(pc_en), 1);
    chk("lu_rt_unused_flush", 32'(id_ex_flush), 0);
    tick();
    // load into $0 never stalls
    idex_rt = 0; id_rs = 0; id_rt = 0; id_uses_rt = 1;
    #1;
    chk("lu_r0_pc_en", 32'(pc_en), 1);
    chk("lu_r0_flush", 32'(id_ex_flush), 0);
    tick();
    chk("lu_r0_stall", stall_cycles, 2);
    chk("sat_stall_2", 32'(s_stall), 2);

    // 3: branch over load-use, MUL/DIV start in ID is squashed
    idle();
    idex_mem_read = 1; idex_rt = 7; id_rs = 7; ex_branch_taken = 1; id_md_start = 1;
    #1;
    chk("br_pc_en", 32'(pc_en), 1);
    chk("br_if_id_flush", 32'(if_id_flush), 1);
    chk("br_id_ex_flush", 32'(id_ex_flush), 1);
    chk("br_ex_mem_flush", 32'(ex_mem_flush), 0);
    chk("br_md_accept", 32'(md_accept), 0);
    tick();
    chk("br_stall", stall_cycles, 2);
    chk("br_md_busy", 32'(md_busy), 0);

    // 4: single MUL/DIV, MFHI waits on it
    idle();
    id_md_start = 1;
    #1;
    chk("md_c0_accept", 32'(md_accept), 1);
    chk("md_c0_pc_en", 32'(pc_en), 1);
    chk("md_c0_hilo_we", 32'(hilo_we), 0);
    tick();
    for (int c = 1; c <= 8; c++) begin
      id_md_start = 0; id_reads_hilo = 1;
      #1;
      chk("md_hilo_pc_en", 32'(pc_en), 0);
      chk("md_hilo_flush", 32'(id_ex_flush), 1);
      chk("md_busy", 32'(md_busy), 1);
      chk("md_hilo_we", 32'(hilo_we), (c == 8) ? 1 : 0);
      tick();
    end
    #1;
    chk("md_c9_pc_en", 32'(pc_en), 1);
    chk("md_c9_busy", 32'(md_busy), 0);
    chk("md_c9_hilo_we", 32'(hilo_we), 0);
    tick();
    chk("md_stall", stall_cycles, 10);
    chk("sat_stall_saturated", 32'(s_stall), 3);

    // 5: back-to-back MULT
    idle();
    id_md_start = 1;
    #1;
    chk("b2b_c0_accept", 32'(md_accept), 1);
    tick();
    for (int c = 1; c <= 8; c++) begin
      #1;
      chk("b2b_wait_accept", 32'(md_accept), 0);
      chk("b2b_wait_pc_en", 32'(pc_en), 0);
      chk("b2b_wait_hilo_we", 32'(hilo_we), (c == 8) ? 1 : 0);
      tick();
    end
    #1;
    chk("b2b_c9_accept", 32'(md_accept), 1);
    chk("b2b_c9_pc_en", 32'(pc_en), 1);
    tick();
    id_md_start = 0;
    for (int c = 10; c <= 17; c++) begin
      #1;
      chk("b2b_second_hilo_we", 32'(hilo_we), (c == 17) ? 1 : 0);
      chk("b2b_second_pc_en", 32'(pc_en), 1);
      tick();
    end
    chk("b2b_done_busy", 32'(md_busy), 0);
    chk("b2b_stall", stall_cycles, 18);

    // 6: exception at cycle 4 of MUL/DIV
    idle();
    id_md_start = 1;
    #1;
    chk("exc_c0_accept", 32'(md_accept), 1);
    tick();
    id_md_start = 0;
    for (int c = 1; c <= 3; c++) tick();
    exc_req = 1;
    #1;
    chk("exc_flushes", {29'd0, if_id_flush, id_ex_flush, ex_mem_flush}, 7);
    chk("exc_pc_en", 32'(pc_en), 1);
    chk("exc_if_id_en", 32'(if_id_en), 0);
    chk("exc_hilo_we", 32'(hilo_we), 0);
    tick();
    exc_req = 0;
    #1;
    chk("exc_c5_busy", 32'(md_busy), 0);
    for (int c = 5; c <= 14; c++) begin
      chk("exc_no_hilo_we", 32'(hilo_we), 0);
      tick();
    end
    chk("exc_stall", stall_cycles, 18);

    // 7: reset in the middle of a MUL/DIV
    idle();
    id_md_start = 1;
    tick();
    id_md_start = 0;
    for (int c = 1; c <= 3; c++) tick();
    rst = 0;
    #1;
    chk("mrst_hilo_we", 32'(hilo_we), 0);
    chk("mrst_pc_en", 32'(pc_en), 0);
    tick();
    rst = 1;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("mrst_no_hilo_we", 32'(hilo_we), 0);
      chk("mrst_busy", 32'(md_busy), 0);
      tick();
    end
    chk("mrst_stall", stall_cycles, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
